// File: rtl/stage_5_wb.sv
// rtl/stage_5_wb.sv - RV32I writeback stage: MEM/WB register, load formatting, regfile write mux
// Optional retire counter enabled by WB_RETIRE_CNT_EN.
module stage_5_wb #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_load_regfile,
  input  logic [2:0]            in_regfilemux_sel,
  input  logic [2:0]            in_funct3,
  input  logic [XLEN-1:0]       in_alu_out,
  input  logic                  in_br_en,
  input  logic [XLEN-1:0]       in_u_imm,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_mem_rdata,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  load_regfile,
  output logic [XLEN-1:0]       regfilemux_out,
  output logic                  wb_valid,
  output logic                  retire
`ifdef WB_RETIRE_CNT_EN
  , output logic [63:0]         retire_count
`endif
);

  logic                  valid_q, valid_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  load_q, load_d;
  logic [2:0]            sel_q, sel_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [XLEN-1:0]       alu_q, alu_d;
  logic                  br_q, br_d;
  logic [XLEN-1:0]       uimm_q, uimm_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;

  // Stall freezes the whole register, including valid, so a held instruction survives a flush.
  always_comb begin
    valid_d  = valid_q;
    rd_d     = rd_q;
    load_d   = load_q;
    sel_d    = sel_q;
    funct3_d = funct3_q;
    alu_d    = alu_q;
    br_d     = br_q;
    uimm_d   = uimm_q;
    pc_d     = pc_q;
    rdata_d  = rdata_q;
    if (!stall) begin
      valid_d  = in_valid & ~flush;
      rd_d     = in_rd;
      load_d   = in_load_regfile;
      sel_d    = in_regfilemux_sel;
      funct3_d = in_funct3;
      alu_d    = in_alu_out;
      br_d     = in_br_en;
      uimm_d   = in_u_imm;
      pc_d     = in_pc;
      rdata_d  = in_mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      rd_q     <= '0;
      load_q   <= 1'b0;
      sel_q    <= '0;
      funct3_q <= '0;
      alu_q    <= '0;
      br_q     <= 1'b0;
      uimm_q   <= '0;
      pc_q     <= '0;
      rdata_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_q     <= rd_d;
      load_q   <= load_d;
      sel_q    <= sel_d;
      funct3_q <= funct3_d;
      alu_q    <= alu_d;
      br_q     <= br_d;
      uimm_q   <= uimm_d;
      pc_q     <= pc_d;
      rdata_q  <= rdata_d;
    end
  end

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_fmt;

  always_comb begin
    ld_byte = rdata_q[8*alu_q[1:0] +: 8];
    ld_half = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (funct3_q)
      3'b000:  ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
      3'b010:  ld_fmt = rdata_q;
      default: ld_fmt = '0;
    endcase
  end

  always_comb begin
    case (sel_q)
      3'd0:    regfilemux_out = alu_q;
      3'd1:    regfilemux_out = {{(XLEN-1){1'b0}}, br_q};
      3'd2:    regfilemux_out = uimm_q;
      3'd3:    regfilemux_out = ld_fmt;
      3'd4:    regfilemux_out = pc_q + XLEN'(4);
      default: regfilemux_out = '0;
    endcase
  end

  assign wb_valid     = valid_q;
  assign rd           = valid_q ? rd_q : '0;
  assign load_regfile = valid_q & load_q & (rd_q != '0);
  assign retire       = valid_q & ~stall;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_count_q, retire_count_d;

  always_comb begin
    retire_count_d = retire_count_q;
    if (retire) retire_count_d = retire_count_q + 64'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_count_q <= '0;
    else     retire_count_q <= retire_count_d;
  end

  assign retire_count = retire_count_q;
`endif

endmodule
